// File: rtl/mips_memsys.sv
// Memory and I/O subsystem for the 8-bit multicycle MIPS core: RAM, LED/switch port, 4-deep TX FIFO, 8N1 transmitter.
// Latency: reads are combinational (zero cycles); writes commit on the rising edge; a push starts its start bit one edge later.
// Backpressure: none toward the core; a push into a full FIFO (with no same-edge pop) is dropped and sets a sticky ovf flag.
module mips_memsys #(
   parameter int WIDTH   = 8,
   parameter int RAMBITS = 7,
   parameter int DIVISOR = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               memread,
   input  logic               memwrite,
   input  logic [WIDTH-1:0]   adr,
   input  logic [WIDTH-1:0]   writedata,
   output logic [WIDTH-1:0]   memdata,
   input  logic               ld_en,
   input  logic [RAMBITS-1:0] ld_adr,
   input  logic [WIDTH-1:0]   ld_data,
   input  logic [WIDTH-1:0]   sw_in,
   output logic [WIDTH-1:0]   led_out,
   output logic               tx_out,
   output logic               tx_busy
);

   // I/O registers live in the top four addresses of the map
   localparam logic [WIDTH-1:0] A_LED    = {{(WIDTH-2){1'b1}}, 2'b00};
   localparam logic [WIDTH-1:0] A_SW     = {{(WIDTH-2){1'b1}}, 2'b01};
   localparam logic [WIDTH-1:0] A_TXDATA = {{(WIDTH-2){1'b1}}, 2'b10};
   localparam logic [WIDTH-1:0] A_STATUS = {{(WIDTH-2){1'b1}}, 2'b11};
   localparam logic [7:0]       TLOAD    = 8'(DIVISOR - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   logic [WIDTH-1:0] ram [0:(1<<RAMBITS)-1];

   logic       adr_ram;
   logic       core_we;
   logic       push;
   logic       pop;
   logic       accept;
   logic       full;
   logic       empty;
   logic       ovf;

   logic [7:0] fifo_mem [0:3];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;

   tx_state_t  state;
   logic [7:0] timer;
   logic [2:0] idx;
   logic [7:0] shreg;

   // The loader owns the write side while it is active; core reads are unaffected
   assign adr_ram = ((adr >> RAMBITS) == '0);
   assign core_we = memwrite & ~ld_en;
   assign full    = (count == 3'd4);
   assign empty   = (count == 3'd0);
   assign pop     = (state == IDLE) & ~empty;
   assign push    = core_we & (adr == A_TXDATA);
   // A full FIFO still takes a push when the transmitter frees a slot on the same edge
   assign accept  = push & (~full | pop);
   assign tx_busy = (state != IDLE);

   // Combinational read mux; returns zero whenever memread is low
   always_comb begin
      memdata = '0;
      if (memread) begin
         if (adr_ram) begin
            memdata = ram[adr[RAMBITS-1:0]];
         end else begin
            case (adr)
               A_LED:    memdata = led_out;
               A_SW:     memdata = sw_in;
               A_STATUS: memdata = {{(WIDTH-4){1'b0}}, ovf, tx_busy, empty, full};
               default:  memdata = '0;
            endcase
         end
      end
   end

   // RAM write port: loader has priority and blocks core stores
   always_ff @(posedge clk) begin
      if (ld_en)
         ram[ld_adr] <= ld_data;
      else if (memwrite && adr_ram)
         ram[adr[RAMBITS-1:0]] <= writedata;
   end

   // LED register and sticky overflow flag; a dropped push beats a STATUS clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_out <= '0;
         ovf     <= 1'b0;
      end else begin
         if (core_we && adr == A_LED)
            led_out <= writedata;
         if (push && !accept)
            ovf <= 1'b1;
         else if (core_we && adr == A_STATUS)
            ovf <= 1'b0;
      end
   end

   // FIFO storage; contents need no reset because count gates validity
   always_ff @(posedge clk) begin
      if (accept)
         fifo_mem[wr_ptr] <= writedata[7:0];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(accept) - 3'(pop);
      end
   end

   // 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each DIVISOR cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         timer  <= '0;
         idx    <= '0;
         shreg  <= '0;
         tx_out <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx_out <= 1'b1;
               if (!empty) begin
                  shreg  <= fifo_mem[rd_ptr];
                  timer  <= TLOAD;
                  tx_out <= 1'b0;
                  state  <= START;
               end
            end
            START: begin
               if (timer == 8'd0) begin
                  timer  <= TLOAD;
                  idx    <= 3'd0;
                  tx_out <= shreg[0];
                  state  <= DATA;
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            DATA: begin
               if (timer == 8'd0) begin
                  timer <= TLOAD;
                  shreg <= {1'b0, shreg[7:1]};
                  if (idx == 3'd7) begin
                     tx_out <= 1'b1;
                     state  <= STOP;
                  end else begin
                     idx    <= idx + 3'd1;
                     tx_out <= shreg[1];
                  end
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            STOP: begin
               if (timer == 8'd0)
                  state <= IDLE;
               else
                  timer <= timer - 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
